// File: rtl/serial_frame_rx.sv
// serial_frame_rx
//   Receives a single-wire frame (start bit, 8 data bits LSB first, stop bit)
//   produced by the 8-bit universal shift register used as a serial
//   transmitter. Rebuilds the byte and hands it downstream over a valid/ready
//   handshake. Framing errors and overruns are reported as sticky flags.
//
// Parameters
//   CLKS_PER_BIT  cp cycles per serial bit (4..1024); mid-bit sampling point
//                 is CLKS_PER_BIT/2 cycles after the detected start edge.
//
// Ports
//   cp         in   clock, rising edge
//   cr         in   synchronous active-high reset, overrides everything
//   sin        in   serial line, idle high, asynchronous to cp
//   clr_err    in   clears frame_err / overrun (a set event wins)
//   ready      in   consumer takes q when valid & ready
//   q          out  last delivered byte, stable while valid
//   valid      out  byte available, held until accepted
//   busy       out  frame in progress (receiver not idle)
//   frame_err  out  sticky: stop bit sampled low
//   overrun    out  sticky: completed byte dropped, previous one unaccepted
module serial_frame_rx #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       cp,
  input  logic       cr,
  input  logic       sin,
  input  logic       clr_err,
  input  logic       ready,
  output logic [7:0] q,
  output logic       valid,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t        state_q, state_d;
  logic          sync1_q, sync2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic [7:0]    q_q, q_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          ovr_q, ovr_d;

  // Events raised on the stop-sample cycle.
  logic          stop_ok, stop_bad;
  logic          s;

  assign s = sync2_q;

  // State register and all sequential storage.
  always_ff @(posedge cp) begin
    if (cr) begin
      state_q <= S_IDLE;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      q_q     <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= sin;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      q_q     <= q_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  // Next-state logic: bit timing, sampling and shift register.
  // The counter restarts at every sample, so each sample lands exactly one
  // bit period after the previous one, anchored at the half-bit start sample.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    sh_d     = sh_q;
    stop_ok  = 1'b0;
    stop_bad = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!s) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = s ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          sh_d  = {s, sh_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (s) begin
            state_d = S_IDLE;
            stop_ok = 1'b1;
          end else begin
            state_d  = S_BREAK;
            stop_bad = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_BREAK: begin
        if (s) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output/handshake logic. A delivery coinciding with acceptance replaces
  // the outgoing byte, so valid stays high; set events beat clr_err.
  always_comb begin
    q_d     = q_q;
    valid_d = valid_q;
    ferr_d  = ferr_q & ~clr_err;
    ovr_d   = ovr_q & ~clr_err;
    if (stop_ok) begin
      if (!valid_q || ready) begin
        q_d     = sh_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
    if (stop_bad) begin
      ferr_d = 1'b1;
    end
  end

  assign q         = q_q;
  assign valid     = valid_q;
  assign busy      = (state_q != S_IDLE);
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// tb_serial_frame_rx
//   Directed bench for serial_frame_rx at CLKS_PER_BIT=8. Frames are driven
//   one bit period at a time starting just after a clock edge (edge E0); the
//   start bit reaches the synchronised line 2 edges later, so t0 is the cycle
//   after E0+2 and valid rises after edge E0+2+4+72+1 = E0+79.
module tb_serial_frame_rx;

  localparam int unsigned C = 8;

  logic       cp;
  logic       cr;
  logic       sin;
  logic       clr_err;
  logic       ready;
  logic [7:0] q;
  logic       valid;
  logic       busy;
  logic       frame_err;
  logic       overrun;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned cyc = 0;
  int unsigned rise_cyc = 0;
  int unsigned valid_hi = 0;
  int unsigned start_cyc;
  int unsigned hi_before;
  logic        valid_prev = 1'b0;

  serial_frame_rx #(.CLKS_PER_BIT(C)) dut (
    .cp        (cp),
    .cr        (cr),
    .sin       (sin),
    .clr_err   (clr_err),
    .ready     (ready),
    .q         (q),
    .valid     (valid),
    .busy      (busy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  initial cp = 1'b0;
  always #5 cp = ~cp;

  always @(posedge cp) cyc <= cyc + 1;

  // Record the cycle of the latest valid rise and total valid-high cycles.
  always @(negedge cp) begin
    if (valid && !valid_prev) rise_cyc = cyc;
    if (valid) valid_hi = valid_hi + 1;
    valid_prev = valid;
  end

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic v);
    sin = v;
    repeat (C) @(posedge cp);
    #1;
  endtask

  // Called at edge+1ns; leaves sin at the stop level afterwards.
  task automatic tx_frame(input logic [7:0] d, input logic stop_v,
                          input int unsigned stop_bits);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    for (int unsigned k = 0; k < stop_bits; k++) send_bit(stop_v);
  endtask

  task automatic align;
    @(posedge cp);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cr = 1'b1; sin = 1'b1; clr_err = 1'b0; ready = 1'b0;
    repeat (3) @(posedge cp);
    #1;
    check_eq("rst_q", {24'd0, q}, 32'h00);
    check_eq("rst_valid", {31'd0, valid}, 0);
    check_eq("rst_busy", {31'd0, busy}, 0);
    check_eq("rst_ferr", {31'd0, frame_err}, 0);
    check_eq("rst_ovr", {31'd0, overrun}, 0);
    cr = 1'b0;
    repeat (4) align();

    // 1) A5 with ready high: one-cycle valid pulse at E0+79.
    ready = 1'b1;
    start_cyc = cyc;
    hi_before = valid_hi;
    tx_frame(8'hA5, 1'b1, 1);
    repeat (3) align();
    check_eq("a5_latency", rise_cyc - start_cyc, 79);
    check_eq("a5_q", {24'd0, q}, 32'hA5);
    check_eq("a5_pulse", valid_hi - hi_before, 1);
    check_eq("a5_flags", {30'd0, frame_err, overrun}, 0);
    check_eq("a5_busy", {31'd0, busy}, 0);

    // 2) ready low, 3C then C3 back to back: overrun, 3C held.
    ready = 1'b0;
    tx_frame(8'h3C, 1'b1, 1);
    check_eq("3c_q", {24'd0, q}, 32'h3C);
    check_eq("3c_valid", {31'd0, valid}, 1);
    check_eq("3c_ovr", {31'd0, overrun}, 0);
    tx_frame(8'hC3, 1'b1, 1);
    repeat (2) align();
    check_eq("c3_q_held", {24'd0, q}, 32'h3C);
    check_eq("c3_valid", {31'd0, valid}, 1);
    check_eq("c3_ovr", {31'd0, overrun}, 1);
    check_eq("c3_ferr", {31'd0, frame_err}, 0);
    clr_err = 1'b1;
    align();
    clr_err = 1'b0;
    check_eq("clr_ovr", {31'd0, overrun}, 0);
    check_eq("clr_q", {24'd0, q}, 32'h3C);
    check_eq("clr_valid", {31'd0, valid}, 1);
    ready = 1'b1;
    align();
    ready = 1'b0;
    check_eq("accept_valid", {31'd0, valid}, 0);

    // 3) 81 with stop held low for two bits: framing error, BREAK.
    tx_frame(8'h81, 1'b0, 2);
    check_eq("brk_ferr", {31'd0, frame_err}, 1);
    check_eq("brk_valid", {31'd0, valid}, 0);
    check_eq("brk_busy", {31'd0, busy}, 1);
    sin = 1'b1;
    repeat (4) align();
    check_eq("brk_idle", {31'd0, busy}, 0);
    tx_frame(8'h7E, 1'b1, 1);
    repeat (2) align();
    check_eq("7e_q", {24'd0, q}, 32'h7E);
    check_eq("7e_valid", {31'd0, valid}, 1);
    check_eq("7e_ferr_sticky", {31'd0, frame_err}, 1);
    clr_err = 1'b1;
    ready = 1'b1;
    align();
    clr_err = 1'b0;
    ready = 1'b0;
    check_eq("clr_ferr", {31'd0, frame_err}, 0);
    check_eq("7e_accepted", {31'd0, valid}, 0);

    // 4) Two-cycle glitch: START aborts at t0+4.
    repeat (4) align();
    hi_before = valid_hi;
    sin = 1'b0;
    repeat (2) align();
    sin = 1'b1;
    repeat (4) align();
    check_eq("glitch_busy_t4", {31'd0, busy}, 1);
    align();
    check_eq("glitch_busy_t5", {31'd0, busy}, 0);
    repeat (20) align();
    check_eq("glitch_novalid", valid_hi - hi_before, 0);
    check_eq("glitch_flags", {30'd0, frame_err, overrun}, 0);

    // 5) cr mid-frame during FF: immediate reset, then 12 received.
    fork
      tx_frame(8'hFF, 1'b1, 1);
      begin
        repeat (40) align();
        check_eq("ff_busy", {31'd0, busy}, 1);
        cr = 1'b1;
        align();
        cr = 1'b0;
        check_eq("cr_q", {24'd0, q}, 32'h00);
        check_eq("cr_valid", {31'd0, valid}, 0);
        check_eq("cr_busy", {31'd0, busy}, 0);
        check_eq("cr_flags", {30'd0, frame_err, overrun}, 0);
      end
    join
    sin = 1'b1;
    repeat (3) align();
    check_eq("ff_no_valid", {31'd0, valid}, 0);
    start_cyc = cyc;
    tx_frame(8'h12, 1'b1, 1);
    repeat (2) align();
    check_eq("12_latency", rise_cyc - start_cyc, 79);
    check_eq("12_q", {24'd0, q}, 32'h12);
    check_eq("12_valid", {31'd0, valid}, 1);

    // 6) ready raised only in the stop-sample cycle of 55: replace, no overrun.
    fork
      tx_frame(8'h55, 1'b1, 1);
      begin
        repeat (78) align();
        check_eq("55_pre_q", {24'd0, q}, 32'h12);
        ready = 1'b1;
        align();
        ready = 1'b0;
        check_eq("55_q", {24'd0, q}, 32'h55);
        check_eq("55_valid", {31'd0, valid}, 1);
        check_eq("55_ovr", {31'd0, overrun}, 0);
      end
    join
    repeat (3) align();
    check_eq("55_hold", {24'd0, q}, 32'h55);
    ready = 1'b1;
    align();
    ready = 1'b0;
    check_eq("55_accept", {31'd0, valid}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
